inst_mem_arbiter: RTL
=====================

Name: inst_mem_arbiter

Overview:
Sequences and shares the single-port, half-word-wide instruction memory between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store into the instruction region).
Each full-word access takes two half-word RAM beats:
- low half at half-address 2*i,
- high half at 2*i+1, with i = addr[ADDR_W-1:1].
The two halves are assembled little-endian: low beat goes to [HALF_W-1:0].
The block raises a pipeline stall while any request is outstanding. It sits between if_stage/mem_stage and the instruction RAM.

Parameters:
ADDR_W, 16, width of requester addresses and ram_addr
HALF_W, 8, RAM data width; a full word is 2*HALF_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held high until if_valid
if_addr  in  ADDR_W  fetch address; bit 0 ignored
if_flush  in  1  discard in-flight fetch (branch/flush)
if_inst  out  2*HALF_W  assembled instruction
if_valid  out  1  one-cycle pulse: if_inst valid
mem_req  in  1  data request; held high until mem_done
mem_we  in  1  1 = write, 0 = read
mem_addr  in  ADDR_W  data address; bit 0 ignored
mem_wdata  in  2*HALF_W  write data
mem_rdata  out  2*HALF_W  read data
mem_done  out  1  one-cycle pulse: access complete
stall_req  out  1  to ctrl; freeze pipeline
ram_ce  out  1  RAM chip enable (`ChipEnable/`ChipDisable)
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM half-word address
ram_wdata  out  HALF_W  RAM write data
ram_rdata  in  HALF_W  RAM read data, valid one cycle after ram_ce

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state changes on the rising edge.
- States: IDLE, LO, HI, FIN. An owner flag (IF/MEM) is latched on acceptance.
- IDLE:
  - If mem_req, accept MEM (latch mem_addr, mem_we, mem_wdata).
  - Else if if_req, accept IF (latch if_addr).
  - Either acceptance goes to LO. Fixed priority: MEM over IF.
- LO: drive ram_ce=1, ram_addr={i,1'b0}, ram_we=latched we (MEM only), ram_wdata=wdata low half. Next state is HI.
- HI:
  - Drive ram_ce=1, ram_addr={i,1'b1}, ram_wdata=high half.
  - Capture ram_rdata into the low half of the assembly register.
  - Next state is FIN.
- FIN:
  - ram_ce=0.
  - Capture ram_rdata into the high half.
  - Register the result to if_inst/if_valid (IF) or mem_rdata/mem_done (MEM).
  - Next state is IDLE.
- Latency: request accepted in IDLE cycle T; RAM beats at T+1 and T+2; valid/done high during T+3; IDLE again at T+4. Throughput is one word per 4 cycles.
- Output timing:
  - ram_* are decoded from the state register; all zero in IDLE and FIN.
  - if_valid and mem_done are registered single-cycle pulses.
- Register holding:
  - if_inst holds its value between fetches.
  - On a MEM write, mem_rdata is unchanged and mem_done still pulses.
  - A MEM write drives ram_we=1 in both LO and HI.
- Latching: addresses and data are latched at acceptance. Requester inputs changing mid-transaction are ignored.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF is accepted at T+4 when it is still requested.
- if_flush during an IF transaction:
  - The RAM beats complete.
  - if_valid is suppressed in FIN; if_inst is not updated.
  - The flush state is sticky until FIN.
  - if_flush in IDLE has no effect.
- stall_req = (if_req & ~if_valid) | (mem_req & ~mem_done). It is combinational and forced 0 while rst=1.
- Address range: half address 2i+1 never overflows (i ≤ 2^(ADDR_W-1)-1). No wrap logic is needed.
- Reset (including mid-transaction):
  - State goes to IDLE; the transaction is abandoned.
  - On the edge where rst is sampled, if_inst, mem_rdata and the assembly register are cleared to `ZeroWord, and if_valid, mem_done are cleared to 0.
  - ram_* are 0 from the following cycle.
  - No pulse is produced for the abandoned transaction.

Decomposition:
- defines.v:
  - state encodings (`ArbIdle, `ArbLo, `ArbHi, `ArbFin);
  - owner encodings (`OwnerIf, `OwnerMem);
  - reuse of `ChipEnable/`ChipDisable, `WriteEnable/`WriteDisable, `ZeroWord, `RstEnable.
- Single FSM module; no sub-module is needed.

Test Plan:
- Fetch: RAM[0x10]=0x34, RAM[0x11]=0x12; if_req=1, if_addr=0x0010 at T.
  - ram_addr 0x10 at T+1, 0x11 at T+2.
  - if_valid=1 and if_inst=0x1234 at T+3.
  - stall_req=1 during T..T+2.
- Odd address: if_addr=0x0011 gives the same result as the fetch test (bit 0 ignored).
- Collision: if_req (0x0010) and mem_req read (mem_addr=0x0020, RAM[0x20]=0xCD, RAM[0x21]=0xAB) both at T.
  - mem_done, mem_rdata=0xABCD at T+3.
  - IF accepted at T+4; if_valid, if_inst=0x1234 at T+7.
- Write then fetch:
  - mem_we=1, mem_addr=0x0030, mem_wdata=0xBEEF gives ram_we=1 with (0x30,0xEF) then (0x31,0xBE), and mem_done at T+3 with mem_rdata unchanged.
  - A subsequent fetch of 0x0030 returns 0xBEEF.
- Flush: fetch at T with if_flush=1 at T+1.
  - No if_valid at T+3; if_inst keeps its prior value.
  - State is IDLE at T+4.
- Reset mid-op: rst=1 at T+2 of a MEM read.
  - ram_ce=0 at T+3; mem_done is never asserted; mem_rdata=0; stall_req=0 while rst=1.
  - Next request completes normally.

Source files
------------

// File: rtl/inst_mem_arbiter_pkg.sv
// rtl/inst_mem_arbiter_pkg.sv - shared encodings for the instruction memory arbiter
package inst_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LO   = 2'd1,
    ARB_HI   = 2'd2,
    ARB_FIN  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF  = 1'b0,
    OWNER_MEM = 1'b1
  } owner_e;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

endpackage

// File: rtl/inst_mem_arbiter.sv
// rtl/inst_mem_arbiter.sv - shares a half-word instruction RAM between fetch and load/store
// Each word is two RAM beats (low half, then high half); MEM wins ties over IF.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int HALF_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  input  logic                  if_flush,
  output logic [2*HALF_W-1:0]   if_inst,
  output logic                  if_valid,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [2*HALF_W-1:0]   mem_wdata,
  output logic [2*HALF_W-1:0]   mem_rdata,
  output logic                  mem_done,
  output logic                  stall_req,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [HALF_W-1:0]     ram_wdata,
  input  logic [HALF_W-1:0]     ram_rdata
);

  localparam int WORD_W = 2 * HALF_W;
  localparam int IDX_W  = ADDR_W - 1;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                flush_q, flush_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [WORD_W-1:0]   if_inst_q, if_inst_d;
  logic                if_valid_q, if_valid_d;
  logic [WORD_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                mem_done_q, mem_done_d;

  logic [WORD_W-1:0]   word_fin;
  logic                fin_if;
  logic                fin_mem_rd;

  // The high half arrives during FIN, so the finished word bypasses the holding register that cycle.
  assign word_fin   = {ram_rdata, asm_q[HALF_W-1:0]};
  assign fin_if     = (state_q == ARB_FIN) && (owner_q == OWNER_IF) && !flush_q;
  assign fin_mem_rd = (state_q == ARB_FIN) && (owner_q == OWNER_MEM) && !we_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    idx_d       = idx_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    flush_d     = flush_q;
    asm_d       = asm_q;
    if_inst_d   = if_inst_q;
    if_valid_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;
    ram_ce      = CHIP_DISABLE;
    ram_we      = WRITE_DISABLE;
    ram_addr    = '0;
    ram_wdata   = '0;

    case (state_q)
      ARB_IDLE: begin
        flush_d = 1'b0;
        if (mem_req) begin
          owner_d = OWNER_MEM;
          idx_d   = mem_addr[ADDR_W-1:1];
          we_d    = mem_we;
          wdata_d = mem_wdata;
          state_d = ARB_LO;
        end else if (if_req) begin
          owner_d = OWNER_IF;
          idx_d   = if_addr[ADDR_W-1:1];
          we_d    = WRITE_DISABLE;
          wdata_d = '0;
          state_d = ARB_LO;
        end
      end
      ARB_LO: begin
        ram_ce    = CHIP_ENABLE;
        ram_addr  = {idx_q, 1'b0};
        ram_we    = (owner_q == OWNER_MEM) && we_q;
        ram_wdata = wdata_q[HALF_W-1:0];
        flush_d   = flush_q | ((owner_q == OWNER_IF) && if_flush);
        state_d   = ARB_HI;
      end
      ARB_HI: begin
        ram_ce              = CHIP_ENABLE;
        ram_addr            = {idx_q, 1'b1};
        ram_we              = (owner_q == OWNER_MEM) && we_q;
        ram_wdata           = wdata_q[WORD_W-1:HALF_W];
        asm_d[HALF_W-1:0]   = ram_rdata;
        flush_d             = flush_q | ((owner_q == OWNER_IF) && if_flush);
        // Pulses are launched here so they are registered and line up with FIN.
        if (owner_q == OWNER_IF) begin
          if_valid_d = !(flush_q || if_flush);
        end else begin
          mem_done_d = 1'b1;
        end
        state_d = ARB_FIN;
      end
      ARB_FIN: begin
        asm_d[WORD_W-1:HALF_W] = ram_rdata;
        if (fin_if) begin
          if_inst_d = word_fin;
        end
        if (fin_mem_rd) begin
          mem_rdata_d = word_fin;
        end
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_IF;
      idx_q       <= '0;
      we_q        <= WRITE_DISABLE;
      wdata_q     <= '0;
      flush_q     <= 1'b0;
      asm_q       <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      flush_q     <= flush_d;
      asm_q       <= asm_d;
      if_inst_q   <= if_inst_d;
      if_valid_q  <= if_valid_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_inst   = fin_if ? word_fin : if_inst_q;
  assign mem_rdata = fin_mem_rd ? word_fin : mem_rdata_q;
  assign if_valid  = if_valid_q;
  assign mem_done  = mem_done_q;
  assign stall_req = !rst && ((if_req && !if_valid_q) || (mem_req && !mem_done_q));

endmodule
